// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush_if,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [1:0]        dcnt_q;
  logic              own_d_q, own_we_q, flush_q;
  logic              mem_en_q, mem_we_q, if_rdy_q, d_rdy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
  logic              grant_if;
  // fetch wins when data is idle or after two back-to-back data grants
  assign grant_if  = if_req & (~d_req | dcnt_q == 2'd2);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_rdy_q & ~flush_if;
  assign d_ready   = d_rdy_q;
  assign stall_f   = if_req & ~if_ready;
  assign stall_m   = d_req & ~d_ready;
  // transaction FSM with registered memory strobes and completion pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      own_d_q     <= 1'b0;
      own_we_q    <= 1'b0;
      flush_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdy_q    <= 1'b0;
      d_rdy_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_rdy_q <= 1'b0;
      d_rdy_q  <= 1'b0;
      case (state_q)
        IDLE: if (d_req | if_req) begin
          own_d_q    <= ~grant_if;
          own_we_q   <= ~grant_if & d_we;
          mem_en_q   <= 1'b1;
          mem_we_q   <= ~grant_if & d_we;
          mem_addr_q <= grant_if ? if_addr : d_addr;
          if (!grant_if) mem_wdata_q <= d_wdata;
          dcnt_q     <= grant_if ? 2'd0 : (dcnt_q == 2'd2 ? 2'd2 : dcnt_q + 2'd1);
          state_q    <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= 3'(LAT - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 3'd0) begin
          if (own_d_q) begin
            d_rdy_q <= 1'b1;
            if (!own_we_q) d_rdata_q <= mem_rdata;
          end else if (!(flush_q | flush_if)) begin
            if_rdy_q   <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
          state_q <= DONE;
        end else cnt_q <= cnt_q - 3'd1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (state_q == DONE) flush_q <= 1'b0;
      else if (flush_if & ~own_d_q & state_q != IDLE) flush_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 0, if_req = 0, flush_if = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ready, d_ready, mem_en, mem_we, stall_f, stall_m;
  int cyc = 0, checks = 0, failures = 0, c;
  typedef struct {bit is_d; logic [31:0] data; int cyc;} rdy_t;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; int cyc;} acc_t;
  rdy_t rq[$];
  acc_t aq[$];
  rdy_t er;
  acc_t ea;
  logic prev_en = 0;
  logic [31:0] store_m [logic [31:0]];
  bit pv [LAT+1];
  logic [31:0] pd [LAT+1];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
    .if_rdata(if_rdata), .if_ready(if_ready), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_en && mem_we) store_m[mem_addr] = mem_wdata;

  always @(posedge clk) begin
    for (int i = LAT; i > 1; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[1] <= mem_en && !mem_we;
    pd[1] <= store_m.exists(mem_addr) ? store_m[mem_addr] : {16'hA5A5, mem_addr[15:0]};
  end
  assign mem_rdata = pv[LAT] ? pd[LAT] : 32'hBAD0BAD0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ready || d_ready) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ready cyc=%0d if_ready=%0b d_ready=%0b", cyc, if_ready, d_ready);
        end else begin
          er = rq.pop_front();
          if ((if_ready && d_ready) || d_ready != er.is_d || (d_ready ? d_rdata : if_rdata) != er.data || cyc != er.cyc) begin
            failures++;
            $display("FAIL ready got d=%0b data=%h cyc=%0d want d=%0b data=%h cyc=%0d",
                     d_ready, d_ready ? d_rdata : if_rdata, cyc, er.is_d, er.data, er.cyc);
          end
        end
      end
      if (mem_en) begin
        checks++;
        if (aq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_mem_en cyc=%0d addr=%h", cyc, mem_addr);
        end else begin
          ea = aq.pop_front();
          if (mem_we != ea.we || mem_addr != ea.addr || (ea.we && mem_wdata != ea.wdata) || cyc != ea.cyc) begin
            failures++;
            $display("FAIL mem_access got we=%0b addr=%h wdata=%h cyc=%0d want we=%0b addr=%h wdata=%h cyc=%0d",
                     mem_we, mem_addr, mem_wdata, cyc, ea.we, ea.addr, ea.wdata, ea.cyc);
          end
        end
      end
      checks++;
      if ((mem_en && prev_en) || (!mem_en && mem_we)) begin
        failures++;
        $display("FAIL mem_en_rule cyc=%0d mem_en=%0b prev=%0b mem_we=%0b", cyc, mem_en, prev_en, mem_we);
      end
    end
    prev_en = mem_en;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int want_d, input int want_i);
    int nd = 0, ni = 0;
    for (int k = 0; k < 100 && (d_req || if_req); k++) begin
      @(negedge clk);
      if (d_ready) nd++;
      if (if_ready) ni++;
      tick();
      if (nd >= want_d) d_req = 0;
      if (ni >= want_i) if_req = 0;
    end
    if (d_req || if_req) begin
      checks++;
      failures++;
      $display("FAIL timeout nd=%0d ni=%0d want_d=%0d want_i=%0d", nd, ni, want_d, want_i);
      d_req = 0;
      if_req = 0;
    end
  endtask

  task automatic reset_vals(input string n);
    chk({n, "_mem_en"}, mem_en, 0);
    chk({n, "_mem_we"}, mem_we, 0);
    chk({n, "_mem_addr"}, mem_addr, 0);
    chk({n, "_mem_wdata"}, mem_wdata, 0);
    chk({n, "_if_ready"}, if_ready, 0);
    chk({n, "_d_ready"}, d_ready, 0);
    chk({n, "_if_rdata"}, if_rdata, 0);
    chk({n, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    if_req = 1;
    repeat (3) tick();
    reset_vals("rst");
    chk("rst_stall_f", stall_f, 1);
    chk("rst_stall_m", stall_m, 0);
    if_req = 0;
    rst_n = 1;
    tick();
    // single fetch
    tick();
    c = cyc;
    if_addr = 32'h100;
    if_req = 1;
    aq.push_back('{0, 32'h100, 0, c + 1});
    rq.push_back('{0, 32'hA5A50100, c + 4});
    @(negedge clk);
    chk("stall_f_c0", stall_f, 1);
    tick();
    tick();
    tick();
    chk("stall_f_c3", stall_f, 1);
    run(0, 1);
    // simultaneous requests: data first, fetch next
    tick();
    c = cyc;
    d_addr = 32'h80;
    d_we = 0;
    if_addr = 32'h100;
    d_req = 1;
    if_req = 1;
    aq.push_back('{0, 32'h80, 0, c + 1});
    aq.push_back('{0, 32'h100, 0, c + 6});
    rq.push_back('{1, 32'hA5A50080, c + 4});
    rq.push_back('{0, 32'hA5A50100, c + 9});
    run(1, 1);
    // both held: D,D,I,D,D,I
    tick();
    c = cyc;
    d_req = 1;
    if_req = 1;
    for (int k = 0; k < 6; k++) begin
      aq.push_back('{0, (k % 3 != 2) ? 32'h80 : 32'h100, 0, c + 5 * k + 1});
      rq.push_back('{k % 3 != 2, (k % 3 != 2) ? 32'hA5A50080 : 32'hA5A50100, c + 5 * k + 4});
    end
    run(4, 2);
    // store leaves d_rdata untouched, then load it back
    tick();
    c = cyc;
    d_we = 1;
    d_addr = 32'h40;
    d_wdata = 32'hDEADBEEF;
    d_req = 1;
    aq.push_back('{1, 32'h40, 32'hDEADBEEF, c + 1});
    rq.push_back('{1, 32'hA5A50080, c + 4});
    run(1, 0);
    d_we = 0;
    tick();
    c = cyc;
    d_req = 1;
    aq.push_back('{0, 32'h40, 0, c + 1});
    rq.push_back('{1, 32'hDEADBEEF, c + 4});
    run(1, 0);
    // flush during WAIT suppresses the fetch completion
    tick();
    c = cyc;
    if_addr = 32'h300;
    if_req = 1;
    aq.push_back('{0, 32'h300, 0, c + 1});
    tick();
    tick();
    flush_if = 1;
    if_req = 0;
    tick();
    flush_if = 0;
    tick();
    chk("flush_if_ready", if_ready, 0);
    tick();
    chk("flush_if_rdata", if_rdata, 32'hA5A50100);
    c = cyc;
    if_addr = 32'h200;
    if_req = 1;
    aq.push_back('{0, 32'h200, 0, c + 1});
    rq.push_back('{0, 32'hA5A50200, c + 4});
    run(0, 1);
    // reset during WAIT aborts without a ready
    tick();
    c = cyc;
    d_addr = 32'h90;
    d_req = 1;
    aq.push_back('{0, 32'h90, 0, c + 1});
    tick();
    tick();
    rst_n = 0;
    d_req = 0;
    tick();
    reset_vals("midrst");
    rst_n = 1;
    repeat (4) tick();
    c = cyc;
    d_req = 1;
    aq.push_back('{0, 32'h90, 0, c + 1});
    rq.push_back('{1, 32'hA5A50090, c + 4});
    run(1, 0);
    repeat (3) tick();
    chk("rq_empty", rq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
